// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (signed/unsigned) for the execute stage.
// Produces {remainder, quotient} after WIDTH+1 cycles, or after one cycle for a zero divisor.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o
);

   // state  | meaning
   // IDLE   | waiting for start_i, outputs cleared
   // BYZERO | zero divisor, result forced to 0
   // ON     | one restoring step per cycle, finalize when cnt==WIDTH
   // END    | result held until start_i drops
   typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]      dvd_q, dvd_d;
   logic [WIDTH-1:0]      dvs_q, dvs_d;
   logic [WIDTH-1:0]      rem_q, rem_d;
   logic                  negq_q, negq_d;
   logic                  negr_q, negr_d;
   logic [2*WIDTH-1:0]    result_q, result_d;
   logic                  ready_q, ready_d;

   logic [WIDTH:0]        shifted;
   logic [WIDTH:0]        diff;
   logic [WIDTH-1:0]      mag1, mag2;
   logic [WIDTH-1:0]      quo_fin, rem_fin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      ready_d  = ready_q;

      // Magnitudes; the most negative value maps onto itself, read as unsigned.
      mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
      mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

      // The dividend register shifts out dividend bits and shifts in quotient bits.
      shifted = {rem_q, dvd_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_q};

      quo_fin = negq_q ? -dvd_q : dvd_q;
      rem_fin = negr_q ? -rem_q : rem_q;

      unique case (state_q)
         S_IDLE: begin
            result_d = '0;
            ready_d  = 1'b0;
            if (start_i && !annul_i) begin
               dvd_d  = mag1;
               dvs_d  = mag2;
               rem_d  = '0;
               cnt_d  = '0;
               negq_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
               negr_d = signed_div_i & opdata1_i[WIDTH-1];
               state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
            end
         end
         S_BYZERO: begin
            if (annul_i) begin
               state_d = S_IDLE;
            end else begin
               result_d = '0;
               ready_d  = 1'b1;
               state_d  = S_END;
            end
         end
         S_ON: begin
            if (annul_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(WIDTH)) begin
               result_d = {rem_fin, quo_fin};
               ready_d  = 1'b1;
               state_d  = S_END;
            end else begin
               if (!diff[WIDTH]) begin
                  rem_d = diff[WIDTH-1:0];
                  dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = shifted[WIDTH-1:0];
                  dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_END: begin
            if (!start_i) begin
               result_d = '0;
               ready_d  = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized operands
// checked against a 64-bit arithmetic reference model.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1, op2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   int errors = 0;
   int checks = 0;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: wide signed/unsigned arithmetic, truncating division (remainder takes dividend sign).
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint la, lb, q, r;
      if (b == 32'h0) return 64'h0;
      la = s ? longint'($signed(a)) : longint'({32'h0, a});
      lb = s ? longint'($signed(b)) : longint'({32'h0, b});
      q = la / lb;
      r = la % lb;
      return {r[31:0], q[31:0]};
   endfunction

   // Start a division, hold start until ready; lat = edges after E0 until ready seen.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit scramble, output logic [63:0] res, output int lat);
      @(negedge clk);
      op1 = a; op2 = b; signed_div = s; start = 1'b1; annul = 1'b0;
      @(posedge clk);
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (scramble && lat == 5) begin
            op1 = $urandom;
            op2 = $urandom | 32'h1;
         end
         if (ready) break;
      end
      res = result;
   endtask

   task automatic drop_start(input string name);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0 || result !== 64'h0) begin
         errors++;
         $display("FAIL %s_release: ready=%b result=%h required ready=0 result=0", name, ready, result);
      end
   endtask

   task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input bit scramble);
      logic [63:0] res, exp;
      int lat, exp_lat;
      exp     = ref_div(a, b, s);
      exp_lat = (b == 32'h0) ? 1 : 33;
      run_div(a, b, s, scramble, res, lat);
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
      end
      checks++;
      if (res !== exp) begin
         errors++;
         $display("FAIL %s_result: a=%h b=%h s=%b got %h required %h", name, a, b, s, res, exp);
      end
      drop_start(name);
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0 || result !== 64'h0) begin
         errors++;
         $display("FAIL reset: ready=%b result=%h required 0/0", ready, result);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed;
      check_div("udiv_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
      checks++;
      if (ref_div(32'd100, 32'd7, 1'b0) !== 64'h00000002_0000000E) begin
         errors++;
         $display("FAIL model_sanity: got %h required 000000020000000e", ref_div(32'd100, 32'd7, 1'b0));
      end
      check_div("sdiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
      check_div("sdiv_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);
      check_div("sdiv_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
      check_div("udiv_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      check_div("udiv_big", 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0);
   endtask

   task automatic test_div_zero;
      logic [63:0] res;
      int lat;
      run_div(32'h12345678, 32'h0, 1'b1, 1'b0, res, lat);
      checks++;
      if (lat !== 1 || res !== 64'h0) begin
         errors++;
         $display("FAIL divzero: lat=%0d result=%h required lat=1 result=0", lat, res);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (ready !== 1'b1 || result !== 64'h0) begin
            errors++;
            $display("FAIL divzero_hold: ready=%b result=%h required 1/0", ready, result);
         end
      end
      drop_start("divzero");
   endtask

   task automatic test_annul;
      bit seen;
      @(negedge clk);
      op1 = 32'd1000; op2 = 32'd3; signed_div = 1'b0; start = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      annul = 1'b1; start = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ready) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL annul_no_ready: ready asserted after annul, required never");
      end
      check_div("after_annul", 32'd100, 32'd7, 1'b0, 1'b0);
      check_div("scramble_u", 32'd100, 32'd7, 1'b0, 1'b1);
      check_div("scramble_s", 32'hFFFF0000, 32'd12345, 1'b1, 1'b1);
   endtask

   task automatic test_random;
      logic [31:0] a, b;
      logic s;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case (i % 4)
            0: b = $urandom;
            1: b = $urandom_range(1, 20);
            2: b = -$urandom_range(1, 20);
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         s = $urandom_range(0, 1);
         check_div("random", a, b, s, 1'b0);
      end
   endtask

   task automatic test_async_reset;
      logic [63:0] res;
      int lat;
      // Reset during ON at cnt=20, between edges.
      @(negedge clk);
      op1 = 32'd500; op2 = 32'd9; signed_div = 1'b0; start = 1'b1;
      @(posedge clk);
      repeat (20) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b0 || result !== 64'h0) begin
         errors++;
         $display("FAIL async_rst_on: ready=%b result=%h required 0/0", ready, result);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      // Reset while a result is held in END must clear it without a clock edge.
      run_div(32'd50, 32'd5, 1'b0, 1'b0, res, lat);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b0 || result !== 64'h0) begin
         errors++;
         $display("FAIL async_rst_end: ready=%b result=%h required 0/0", ready, result);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check_div("after_rst_9_3", 32'd9, 32'd3, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_annul();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
